// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types for the SPI master controller:
//   t_spi_if_ro : request/config from the register/FIFO front end
//   t_spi_if_ri : status and read data back to the front end
//   t_spi_state : controller state encoding
//   msb_idx()   : word-length code -> index of the first (MSB) bit
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef struct packed {
    logic        strt;      // level start, looked at in IDLE only
    logic [31:0] rwdata;    // current write word
    logic [1:0]  wd_len;    // write word is 8*(wd_len+1) bits
    logic        wd_lst;    // current write word is the last one
    logic        wd_empty;  // no write word available
    logic        rdata_en;  // run a read phase
    logic [1:0]  rd_len;    // read word is 8*(rd_len+1) bits
    logic        rd_lst;    // current read word is the last one
    logic [1:0]  slv_sel;   // slave select, captured at start
  } t_spi_if_ro;

  typedef struct packed {
    logic        busy;      // out of IDLE
    logic        wd_rd;     // write-word pop
    logic [31:0] rdata;     // right-aligned read word
    logic        rdata_vld; // rdata strobe
    logic        done;      // transaction finished
    logic        tmo;       // watchdog abort
    logic [1:0]  slv_sel;   // captured slave select
  } t_spi_if_ri;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_WR_LOAD,
    S_WR_SHIFT,
    S_RD_LOAD,
    S_RD_SHIFT,
    S_CS_HOLD,
    S_GAP
  } t_spi_state;

  localparam int CNT_W = 4;

  // Word of 8*(len+1) bits: its MSB sits at index 8*(len+1)-1 = {len, 3'b111}.
  function automatic logic [4:0] msb_idx(input logic [1:0] len);
    return {len, 3'b111};
  endfunction

endpackage

// File: rtl/spi_edge_det.sv
// -----------------------------------------------------------------------------
// spi_edge_det
// Rising-edge detector in the i_clk domain.
//   i_clk  : system clock
//   i_rst  : asynchronous active-high reset
//   i_sig  : level input (strobe or tick)
//   o_rise : high for the one i_clk cycle in which i_sig is seen rising
// -----------------------------------------------------------------------------
module spi_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_prev <= 1'b0;
    else       r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/spi_ctrl.sv
// -----------------------------------------------------------------------------
// spi_ctrl
// Single-chip-select SPI master. One transaction per start: optional write
// phase (1+ words), optional read phase (1+ words), framed by spi_csn.
// Bit timing comes from clk_en rising edges; everything runs on clk.
//   clk, rst     : system clock, asynchronous active-high reset
//   clk_en       : SPI half-period step strobe (rising edge = one step)
//   clk_1k_fp    : 1 kHz watchdog tick (rising edge = one tick)
//   spi_csn/clk/mosi/miso : SPI pins
//   r_spi_cpha/cpol : clock mode, captured when leaving IDLE
//   spi_ifi_ro   : request/config struct in
//   spi_ifi_ri   : status/read-data struct out
// -----------------------------------------------------------------------------
module spi_ctrl
  import spi_pkg::*;
#(
  parameter int CS_SETUP_HT = 1,  // half-periods csn-low -> first edge, last edge -> csn-high
  parameter int CS_GAP_HT   = 2   // minimum csn-high half-periods between transactions
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       clk_1k_fp,
  output logic       spi_csn,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  input  logic       r_spi_cpha,
  input  logic       r_spi_cpol,
  input  t_spi_if_ro spi_ifi_ro,
  output t_spi_if_ri spi_ifi_ri
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_HT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP_HT - 1);

  logic w_step;
  logic w_tick;

  spi_edge_det u_step_det (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_sig  (clk_en),
    .o_rise (w_step)
  );

  spi_edge_det u_tick_det (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_sig  (clk_1k_fp),
    .o_rise (w_tick)
  );

  t_spi_state       r_state;
  logic [CNT_W-1:0] r_cnt;      // half-period counter for setup/hold/gap
  logic             r_cpol;
  logic             r_cpha;
  logic             r_sclk_ph;  // 0 = spi_clk at idle level, 1 = active level
  logic             r_csn;
  logic             r_mosi;
  logic [4:0]       r_bit;      // index of the bit currently on the wire
  logic [31:0]      r_sh;       // write word being shifted out
  logic [31:0]      r_rd;       // read bits gathered so far
  logic             r_wlst;
  logic             r_rlst;
  logic             r_wdog;     // one tick already seen while stalled
  t_spi_if_ri       r_ri;

  logic        w_lead;
  logic        w_trail;
  logic [31:0] w_rd_nxt;
  logic [4:0]  w_bit_dn;

  // r_sclk_ph tells which edge the next step produces.
  assign w_lead   = w_step & ~r_sclk_ph;
  assign w_trail  = w_step &  r_sclk_ph;
  assign w_rd_nxt = {r_rd[30:0], spi_miso};
  assign w_bit_dn = r_bit - 5'd1;

  // Outside a transaction spi_clk tracks the live cpol input so that it
  // shows the idle level even while rst is held.
  assign spi_clk    = r_ri.busy ? (r_cpol ^ r_sclk_ph) : r_spi_cpol;
  assign spi_csn    = r_csn;
  assign spi_mosi   = r_mosi;
  assign spi_ifi_ri = r_ri;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_sclk_ph <= 1'b0;
      r_csn     <= 1'b1;
      r_mosi    <= 1'b0;
      r_bit     <= '0;
      r_sh      <= '0;
      r_rd      <= '0;
      r_wlst    <= 1'b0;
      r_rlst    <= 1'b0;
      r_wdog    <= 1'b0;
      r_ri      <= '0;
    end else begin
      r_ri.wd_rd     <= 1'b0;
      r_ri.rdata_vld <= 1'b0;
      r_ri.done      <= 1'b0;
      r_ri.tmo       <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_step && spi_ifi_ro.strt) begin
            r_cpol       <= r_spi_cpol;
            r_cpha       <= r_spi_cpha;
            r_ri.slv_sel <= spi_ifi_ro.slv_sel;
            r_ri.busy    <= 1'b1;
            r_csn        <= 1'b0;
            r_mosi       <= 1'b0;
            r_sclk_ph    <= 1'b0;
            r_cnt        <= '0;
            r_wdog       <= 1'b0;
            r_state      <= S_CS_SETUP;
          end
        end

        S_CS_SETUP: begin
          if (w_step) begin
            if (r_cnt == SETUP_LAST) begin
              r_cnt <= '0;
              if (!spi_ifi_ro.wd_empty)     r_state <= S_WR_LOAD;
              else if (spi_ifi_ro.rdata_en) r_state <= S_RD_LOAD;
              else                          r_state <= S_CS_HOLD;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        // Not gated by clk_en: a word present is loaded the same cycle.
        S_WR_LOAD: begin
          if (!spi_ifi_ro.wd_empty) begin
            r_sh       <= spi_ifi_ro.rwdata;
            r_bit      <= msb_idx(spi_ifi_ro.wd_len);
            r_wlst     <= spi_ifi_ro.wd_lst;
            r_ri.wd_rd <= 1'b1;
            r_wdog     <= 1'b0;
            // cpha=0 needs the MSB on the wire before the first leading edge.
            if (!r_cpha) r_mosi <= spi_ifi_ro.rwdata[msb_idx(spi_ifi_ro.wd_len)];
            r_state    <= S_WR_SHIFT;
          end else if (w_tick) begin
            if (r_wdog) begin
              r_ri.tmo <= 1'b1;
              r_wdog   <= 1'b0;
              r_cnt    <= '0;
              r_state  <= S_CS_HOLD;
            end else begin
              r_wdog <= 1'b1;
            end
          end
        end

        S_WR_SHIFT: begin
          if (w_step) begin
            r_sclk_ph <= ~r_sclk_ph;
            if (w_lead) begin
              if (r_cpha) r_mosi <= r_sh[r_bit];
            end else if (w_trail) begin
              if (r_bit == '0) begin
                r_cnt <= '0;
                if (!r_wlst)                  r_state <= S_WR_LOAD;
                else if (spi_ifi_ro.rdata_en) r_state <= S_RD_LOAD;
                else                          r_state <= S_CS_HOLD;
              end else begin
                r_bit <= w_bit_dn;
                if (!r_cpha) r_mosi <= r_sh[w_bit_dn];
              end
            end
          end
        end

        S_RD_LOAD: begin
          r_rd    <= '0;
          r_bit   <= msb_idx(spi_ifi_ro.rd_len);
          r_rlst  <= spi_ifi_ro.rd_lst;
          r_mosi  <= 1'b0;
          r_state <= S_RD_SHIFT;
        end

        S_RD_SHIFT: begin
          if (w_step) begin
            r_sclk_ph <= ~r_sclk_ph;
            if (w_lead) begin
              if (!r_cpha) r_rd <= w_rd_nxt;
            end else if (w_trail) begin
              if (r_cpha) r_rd <= w_rd_nxt;
              if (r_bit == '0) begin
                // For cpha=1 the last bit is sampled on this very edge.
                r_ri.rdata     <= r_cpha ? w_rd_nxt : r_rd;
                r_ri.rdata_vld <= 1'b1;
                r_cnt          <= '0;
                r_state        <= r_rlst ? S_CS_HOLD : S_RD_LOAD;
              end else begin
                r_bit <= w_bit_dn;
              end
            end
          end
        end

        S_CS_HOLD: begin
          if (w_step) begin
            if (r_cnt == SETUP_LAST) begin
              r_csn     <= 1'b1;
              r_ri.done <= 1'b1;
              r_cnt     <= '0;
              r_state   <= S_GAP;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        S_GAP: begin
          if (w_step) begin
            if (r_cnt == GAP_LAST) begin
              r_ri.busy <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_ctrl
// Directed bench for spi_ctrl: a table of single-transaction vectors with
// hand-computed results, plus hand-written stall, watchdog and mid-transfer
// reset sequences. A negedge monitor acts as the SPI slave and gathers edges,
// MOSI bits and status pulses.
// -----------------------------------------------------------------------------
module tb_spi_ctrl;
  import spi_pkg::*;

  logic clk = 1'b0, rst = 1'b1, clk_en = 1'b0, clk_1k_fp = 1'b0;
  logic cpol = 1'b0, cpha = 1'b0, spi_miso = 1'b0;
  logic spi_csn, spi_clk, spi_mosi;
  t_spi_if_ro ro = '0;
  t_spi_if_ri ri;

  spi_ctrl #(.CS_SETUP_HT(1), .CS_GAP_HT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .clk_1k_fp  (clk_1k_fp),
    .spi_csn    (spi_csn),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .r_spi_cpha (cpha),
    .r_spi_cpol (cpol),
    .spi_ifi_ro (ro),
    .spi_ifi_ri (ri)
  );

  always #5 clk = ~clk;

  // One clk_en pulse every 4 clk cycles.
  initial forever begin
    repeat (3) @(posedge clk);
    #1 clk_en = 1'b1;
    @(posedge clk);
    #1 clk_en = 1'b0;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / slave model ----------------
  int          txn_id = 0, mon_id = 0, wbits = 0;
  logic [63:0] seq_init = '0, seq = '0;
  int          m_edges = 0, m_samp = 0, m_rd_ones = 0, m_unstable = 0;
  int          m_wdrd = 0, m_rvld = 0, m_done = 0, m_tmo = 0;
  logic [31:0] m_mosi = '0, m_rdata = '0;
  logic        prev_sclk = 1'b0, prev_mosi = 1'b0, m_lead = 1'b0;

  initial forever begin
    @(negedge clk);
    if (mon_id != txn_id) begin
      mon_id = txn_id;
      m_edges = 0; m_samp = 0; m_rd_ones = 0; m_unstable = 0;
      m_wdrd = 0; m_rvld = 0; m_done = 0; m_tmo = 0;
      m_mosi = '0; m_rdata = '0;
      seq = seq_init;
      spi_miso = cpha ? 1'b0 : seq_init[63];
    end
    if (!spi_csn && spi_clk !== prev_sclk) begin
      m_edges++;
      m_lead = (prev_sclk == cpol);
      if (m_lead == !cpha) begin
        if (spi_mosi !== prev_mosi) m_unstable++;
        if (m_samp < wbits) m_mosi = {m_mosi[30:0], spi_mosi};
        else if (spi_mosi)  m_rd_ones++;
        m_samp++;
      end
      if (cpha && m_lead) begin
        spi_miso = seq[63];
        seq = seq << 1;
      end else if (!cpha && !m_lead) begin
        seq = seq << 1;
        spi_miso = seq[63];
      end
    end
    if (ri.wd_rd) m_wdrd++;
    if (ri.rdata_vld) begin m_rvld++; m_rdata = ri.rdata; end
    if (ri.done) m_done++;
    if (ri.tmo) m_tmo++;
    prev_sclk = spi_clk;
    prev_mosi = spi_mosi;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        cpol, cpha, wr, rd;
    logic [31:0] wdata;
    logic [1:0]  wl, rl, sel;
    logic [63:0] seq;
    int          edges;
    logic [31:0] mosi;
    int          wdrd, rvld;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[10];

  function automatic vec_t mk(input logic cp, input logic ch, input logic wr, input logic rd,
                              input logic [31:0] wd, input logic [1:0] wl, input logic [1:0] rl,
                              input logic [1:0] sel, input logic [63:0] sq, input int edges,
                              input logic [31:0] mosi, input int wdrd, input int rvld,
                              input logic [31:0] rdata);
    vec_t v;
    v.cpol = cp; v.cpha = ch; v.wr = wr; v.rd = rd; v.wdata = wd; v.wl = wl; v.rl = rl;
    v.sel = sel; v.seq = sq; v.edges = edges; v.mosi = mosi; v.wdrd = wdrd; v.rvld = rvld;
    v.rdata = rdata;
    return v;
  endfunction

  task automatic start_txn(input string tag);
    txn_id++;
    repeat (2) @(negedge clk);
    ro.strt = 1'b1;
    for (int k = 0; k < 100 && !ri.busy; k++) @(negedge clk);
    chk({tag, "_busy_start"}, ri.busy, 1);
    chk({tag, "_idle_start"}, spi_clk, cpol);
    chk({tag, "_csn_low"}, spi_csn, 0);
    ro.strt = 1'b0;
  endtask

  task automatic finish_txn(input string tag);
    for (int k = 0; k < 3000 && m_done == 0; k++) @(negedge clk);
    chk({tag, "_done"}, m_done, 1);
    chk({tag, "_csn_end"}, spi_csn, 1);
    chk({tag, "_idle_end"}, spi_clk, cpol);
    for (int k = 0; k < 100 && ri.busy; k++) @(negedge clk);
    chk({tag, "_busy_end"}, ri.busy, 0);
  endtask

  int stall_bad;

  initial begin
    // 0xAA write + 32-bit read, MISO low / high, then 0x5A in all four modes
    vt[0] = mk(0,0,1,1,32'hAAAAAAAA,0,3,1,64'h0,                 80,32'hAA,    1,1,32'h00000000);
    vt[1] = mk(0,0,1,1,32'hAAAAAAAA,0,3,2,64'hFFFFFFFFFFFFFFFF,  80,32'hAA,    1,1,32'hFFFFFFFF);
    vt[2] = mk(0,0,1,0,32'h5A,      0,0,0,64'h0,                 16,32'h5A,    1,0,32'h0);
    vt[3] = mk(0,1,1,0,32'h5A,      0,0,3,64'h0,                 16,32'h5A,    1,0,32'h0);
    vt[4] = mk(1,0,1,0,32'h5A,      0,0,1,64'h0,                 16,32'h5A,    1,0,32'h0);
    vt[5] = mk(1,1,1,0,32'h5A,      0,0,2,64'h0,                 16,32'h5A,    1,0,32'h0);
    vt[6] = mk(1,1,1,1,32'h1234,    1,1,3,64'h0000BEEF00000000,  64,32'h1234,  1,1,32'h0000BEEF);
    vt[7] = mk(0,1,0,1,32'h0,       0,3,1,64'hDEADBEEF00000000,  64,32'h0,     0,1,32'hDEADBEEF);
    vt[8] = mk(1,0,1,0,32'hABCDEF,  2,0,0,64'h0,                 48,32'hABCDEF,1,0,32'h0);
    vt[9] = mk(0,0,1,1,32'h80,      0,0,2,64'h0081000000000000,  32,32'h80,    1,1,32'h81);

    // ---- reset state ----
    cpol = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_csn", spi_csn, 1);
    chk("rst_sclk_cpol1", spi_clk, 1);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_ri", ri, '0);
    cpol = 1'b0;
    #1 chk("rst_sclk_cpol0", spi_clk, 0);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);

    // ---- table ----
    for (int i = 0; i < 10; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      cpol = vt[i].cpol; cpha = vt[i].cpha; seq_init = vt[i].seq;
      wbits = vt[i].wr ? 8 * (int'(vt[i].wl) + 1) : 0;
      ro = '0;
      ro.rwdata = vt[i].wdata; ro.wd_len = vt[i].wl; ro.wd_lst = 1'b1;
      ro.wd_empty = !vt[i].wr; ro.rdata_en = vt[i].rd; ro.rd_len = vt[i].rl;
      ro.rd_lst = 1'b1; ro.slv_sel = vt[i].sel;
      start_txn(t);
      finish_txn(t);
      chk({t, "_edges"}, m_edges, vt[i].edges);
      chk({t, "_mosi"}, m_mosi, vt[i].mosi);
      chk({t, "_mosi_unstable"}, m_unstable, 0);
      chk({t, "_mosi_rd_ones"}, m_rd_ones, 0);
      chk({t, "_wd_rd"}, m_wdrd, vt[i].wdrd);
      chk({t, "_rvld"}, m_rvld, vt[i].rvld);
      chk({t, "_rdata"}, m_rdata, vt[i].rdata);
      chk({t, "_tmo"}, m_tmo, 0);
      chk({t, "_slv_sel"}, ri.slv_sel, vt[i].sel);
    end

    // ---- two write words with a 5-step stall between them ----
    cpol = 1'b0; cpha = 1'b0; seq_init = '0; wbits = 16;
    ro = '0; ro.rwdata = 32'h3C; ro.wd_lst = 1'b0; ro.wd_empty = 1'b0;
    start_txn("stall");
    for (int k = 0; k < 500 && m_wdrd < 1; k++) @(negedge clk);
    ro.wd_empty = 1'b1;
    for (int k = 0; k < 500 && m_edges < 16; k++) @(negedge clk);
    stall_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (spi_clk !== cpol || spi_csn !== 1'b0) stall_bad++;
    end
    chk("stall_idle_csn_low", stall_bad, 0);
    chk("stall_no_edges", m_edges, 16);
    ro.rwdata = 32'hC5; ro.wd_lst = 1'b1; ro.wd_empty = 1'b0;
    for (int k = 0; k < 100 && m_wdrd < 2; k++) @(negedge clk);
    ro.wd_empty = 1'b1;
    finish_txn("stall");
    chk("stall_wd_rd", m_wdrd, 2);
    chk("stall_edges", m_edges, 32);
    chk("stall_mosi", m_mosi, 32'h3CC5);
    chk("stall_unstable", m_unstable, 0);

    // ---- watchdog: write word not last, then FIFO stays empty ----
    ro = '0; ro.rwdata = 32'h96; ro.wd_lst = 1'b0; ro.wd_empty = 1'b0; wbits = 8;
    start_txn("wdog");
    for (int k = 0; k < 500 && m_wdrd < 1; k++) @(negedge clk);
    ro.wd_empty = 1'b1;
    for (int k = 0; k < 500 && m_edges < 16; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    clk_1k_fp = 1'b1; repeat (2) @(negedge clk); clk_1k_fp = 1'b0;
    repeat (10) @(negedge clk);
    chk("wdog_one_tick_tmo", m_tmo, 0);
    chk("wdog_one_tick_csn", spi_csn, 0);
    clk_1k_fp = 1'b1; repeat (2) @(negedge clk); clk_1k_fp = 1'b0;
    finish_txn("wdog");
    chk("wdog_tmo", m_tmo, 1);
    chk("wdog_edges", m_edges, 16);
    chk("wdog_mosi", m_mosi, 32'h96);

    // ---- reset in the middle of a read ----
    cpol = 1'b1; cpha = 1'b0; seq_init = 64'hDEADBEEF00000000; wbits = 0;
    ro = '0; ro.wd_empty = 1'b1; ro.rdata_en = 1'b1; ro.rd_len = 2'd3; ro.rd_lst = 1'b1;
    start_txn("rstmid");
    for (int k = 0; k < 500 && m_edges < 10; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_csn", spi_csn, 1);
    chk("rstmid_sclk", spi_clk, 1);
    chk("rstmid_busy", ri.busy, 0);
    chk("rstmid_rvld_now", ri.rdata_vld, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("rstmid_rvld", m_rvld, 0);
    chk("rstmid_csn_after", spi_csn, 1);
    chk("rstmid_edges", m_edges, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
